// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared constants and helpers for the M:SS countdown timer.
//  - FSM state encodings
//  - BCD digit limits
//  - preset clamp limits and the seconds clamp/split helper
package countdown_timer_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    localparam logic [3:0] MIN_MAX = 4'd9;
    localparam logic [5:0] SEC_MAX = 6'd59;

    function automatic logic [3:0] clamp_min(input logic [3:0] m);
        return (m > MIN_MAX) ? MIN_MAX : m;
    endfunction

    // Returns {tens, ones} of the clamped seconds preset.
    function automatic logic [7:0] split_sec(input logic [5:0] s);
        logic [5:0] c;
        logic [3:0] t;
        logic [3:0] o;
        c = (s > SEC_MAX) ? SEC_MAX : s;
        t = 4'(c / 6'd10);
        o = 4'(c - 6'(t) * 6'd10);
        return {t, o};
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit with parallel load.
//  clk, reset   : clock, async active-high reset (value -> 0)
//  load/load_val: load value (takes priority over dec)
//  dec          : decrement by one; 0 wraps to MAX
//  value        : current digit
//  borrow_out   : dec while at 0, i.e. the next digit up must decrement
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] value,
    output logic       borrow_out
);

    assign borrow_out = dec & (value == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= 4'd0;
        else if (load)
            value <= load_val;
        else if (dec)
            value <= (value == 4'd0) ? MAX : value - 4'd1;
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Game countdown timer: M:SS BCD cascade (9:59 max) driven by a 1 Hz
// prescaled tick, gated by an IDLE/RUN/PAUSED/EXPIRED controller.
//  clk, reset          : clock, async active-high reset
//  load, load_min/sec  : load clamped preset and return to IDLE
//  start, pause        : begin/resume and freeze counting (load > pause > start)
//  min_digit, sec_tens, sec_ones : BCD display digits
//  running             : high in RUN
//  tick                : one-cycle pulse per accepted decrement
//  expired             : one-cycle pulse on the decrement that reaches 0:00
//  done                : level, follows EXPIRED one cycle later
module countdown_timer_ctrl
    import countdown_timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       tick,
    output logic       expired,
    output logic       done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    logic [1:0]    state;
    logic [PW-1:0] presc;

    logic [3:0] ld_min;
    logic [7:0] ld_sec;
    logic       dec;
    logic       ones_borrow;
    logic       tens_borrow;
    logic       min_borrow;
    logic       at_zero;
    logic       last_sec;

    assign ld_min = clamp_min(load_min);
    assign ld_sec = split_sec(load_sec);

    assign at_zero  = (min_digit == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign last_sec = (min_digit == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

    // A decrement happens on the prescaler's last count in RUN; load suppresses it.
    assign dec = (state == ST_RUN) && (presc == PRESC_TOP) && !load;

    assign running = (state == ST_RUN);

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_ones (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_sec[3:0]),
        .dec(dec), .value(sec_ones), .borrow_out(ones_borrow)
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_tens (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_sec[7:4]),
        .dec(ones_borrow), .value(sec_tens), .borrow_out(tens_borrow)
    );

    // Minutes never borrow further: counting stops at 0:00.
    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min (
        .clk(clk), .reset(reset), .load(load), .load_val(ld_min),
        .dec(tens_borrow), .value(min_digit), .borrow_out(min_borrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            tick    <= 1'b0;
            expired <= 1'b0;
            done    <= (state == ST_EXPIRED);
            if (load) begin
                state <= ST_IDLE;
                presc <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !pause && !at_zero) begin
                            state <= ST_RUN;
                            presc <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (presc == PRESC_TOP) begin
                            // The tick completes even if pause arrives with it.
                            tick  <= 1'b1;
                            presc <= '0;
                            if (last_sec) begin
                                expired <= 1'b1;
                                state   <= ST_EXPIRED;
                            end else if (pause) begin
                                state <= ST_PAUSED;
                            end
                        end else if (pause) begin
                            // Hold the partial second so resume continues it.
                            state <= ST_PAUSED;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (start && !pause)
                            state <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
module tb_countdown_timer_ctrl;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       pause;
    logic [3:0] min_digit;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       tick;
    logic       expired;
    logic       done;

    countdown_timer_ctrl #(.TICK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .load(load), .load_min(load_min),
        .load_sec(load_sec), .start(start), .pause(pause),
        .min_digit(min_digit), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .tick(tick), .expired(expired), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Reference model: remaining time in plain seconds plus elapsed cycles
    // within the current second.
    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXP} mstate_t;
    mstate_t m_st;
    int      m_secs;
    int      m_phase;
    bit      m_tick, m_exp, m_done;

    function automatic void model_reset();
        m_st = M_IDLE; m_secs = 0; m_phase = 0;
        m_tick = 0; m_exp = 0; m_done = 0;
    endfunction

    function automatic void model_edge(bit ld, int lm, int ls, bit st, bit ps);
        bit done_n;
        done_n = (m_st == M_EXP);
        m_tick = 0;
        m_exp  = 0;
        if (ld) begin
            m_secs  = (lm > 9 ? 9 : lm) * 60 + (ls > 59 ? 59 : ls);
            m_phase = 0;
            m_st    = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: if (st && !ps && m_secs != 0) begin m_st = M_RUN; m_phase = 0; end
                M_RUN: begin
                    if (m_phase == DIV - 1) begin
                        m_secs  = m_secs - 1;
                        m_tick  = 1;
                        m_phase = 0;
                        if (m_secs == 0) begin m_exp = 1; m_st = M_EXP; end
                        else if (ps) m_st = M_PAUSED;
                    end else if (ps) m_st = M_PAUSED;
                    else m_phase = m_phase + 1;
                end
                M_PAUSED: if (st && !ps) m_st = M_RUN;
                default: ;
            endcase
        end
        m_done = done_n;
    endfunction

    function automatic logic [15:0] mvec();
        return {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
                m_st == M_RUN, m_tick, m_exp, m_done};
    endfunction

    function automatic logic [15:0] ovec();
        return {min_digit, sec_tens, sec_ones, running, tick, expired, done};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic cycle(input bit ld, input int lm, input int ls, input bit st, input bit ps);
        load = ld; load_min = 4'(lm); load_sec = 6'(ls); start = st; pause = ps;
        @(posedge clk);
        model_edge(ld, lm, ls, st, ps);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        n_chk++;
        if (ovec() !== 16'h0) $display("FAIL reset_init: got %h want %h", ovec(), 16'h0);
        else n_pass++;
        @(posedge clk); #1; reset = 0;
        // Reset asserted mid-count at 0:37.
        cycle(1, 0, 37, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (3) idle();
        #2 reset = 1;
        #1 model_reset();
        n_chk++;
        if (ovec() !== 16'h0) $display("FAIL reset_async: got %h want %h", ovec(), 16'h0);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (ovec() !== mvec()) $display("FAIL reset_hold: got %h want %h", ovec(), mvec());
        else n_pass++;
        reset = 0;
    endtask

    task automatic test_expiry();
        cycle(1, 0, 2, 0, 0);
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            n_chk++;
            if (ovec() !== mvec()) $display("FAIL exp_pre%0d: got %h want %h", i, ovec(), mvec());
            else n_pass++;
        end
        idle();
        n_chk++;
        if ({sec_ones, tick} !== {4'd1, 1'b1} || ovec() !== mvec())
            $display("FAIL exp_first_tick: got %h want %h", ovec(), mvec());
        else n_pass++;
        repeat (3) idle();
        idle();
        n_chk++;
        if ({min_digit, sec_tens, sec_ones, tick, expired, done} !== {12'h000, 3'b110} || ovec() !== mvec())
            $display("FAIL exp_zero: got %h want %h", ovec(), mvec());
        else n_pass++;
        idle();
        n_chk++;
        if ({tick, expired, done} !== 3'b001 || ovec() !== mvec())
            $display("FAIL exp_done: got %h want %h", ovec(), mvec());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, i[0], i[1]);
            n_chk++;
            if (tick !== 1'b0 || ovec() !== mvec())
                $display("FAIL exp_hold%0d: got %h want %h", i, ovec(), mvec());
            else n_pass++;
        end
    endtask

    task automatic test_cascade();
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (4) idle();
        n_chk++;
        if ({min_digit, sec_tens, sec_ones, tick} !== {12'h059, 1'b1} || ovec() !== mvec())
            $display("FAIL cascade_100: got %h want %h", ovec(), mvec());
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        cycle(1, 0, 10, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (2) idle();
        repeat (10) cycle(0, 0, 0, 0, 1);
        n_chk++;
        if ({running, sec_tens, sec_ones} !== {1'b0, 8'h10} || ovec() !== mvec())
            $display("FAIL pause_held: got %h want %h", ovec(), mvec());
        else n_pass++;
        cycle(0, 0, 0, 1, 0);
        idle();
        n_chk++;
        if (tick !== 1'b0 || ovec() !== mvec()) $display("FAIL resume_early: got %h want %h", ovec(), mvec());
        else n_pass++;
        idle();
        n_chk++;
        if ({tick, sec_tens, sec_ones} !== {1'b1, 8'h09} || ovec() !== mvec())
            $display("FAIL resume_tick: got %h want %h", ovec(), mvec());
        else n_pass++;
    endtask

    task automatic test_clamp();
        cycle(1, 12, 63, 0, 0);
        n_chk++;
        if ({min_digit, sec_tens, sec_ones} !== 12'h959 || ovec() !== mvec())
            $display("FAIL clamp: got %h want %h", ovec(), mvec());
        else n_pass++;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        idle();
        n_chk++;
        if ({running, tick, min_digit, sec_tens, sec_ones} !== 14'h0 || ovec() !== mvec())
            $display("FAIL start_zero: got %h want %h", ovec(), mvec());
        else n_pass++;
    endtask

    task automatic test_load_on_tick();
        cycle(1, 0, 5, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (3) idle();
        cycle(1, 0, 30, 0, 0);
        n_chk++;
        if ({running, tick, sec_tens, sec_ones} !== {2'b00, 8'h30} || ovec() !== mvec())
            $display("FAIL load_on_tick: got %h want %h", ovec(), mvec());
        else n_pass++;
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        n_chk++;
        if (running !== 1'b0 || ovec() !== mvec())
            $display("FAIL pause_start_run: got %h want %h", ovec(), mvec());
        else n_pass++;
    endtask

    task automatic test_random();
        int lm, ls;
        bit ld, st, ps;
        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 20);
            ps = ($urandom_range(0, 99) < 6);
            lm = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 15));
            ls = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 63));
            cycle(ld, lm, ls, st, ps);
            n_chk++;
            if (ovec() !== mvec()) $display("FAIL random%0d: got %h want %h", i, ovec(), mvec());
            else n_pass++;
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        load = 0; load_min = 0; load_sec = 0; start = 0; pause = 0;
        reset = 1;
        model_reset();
        #3;
        test_reset();
        test_expiry();
        test_cascade();
        test_pause_resume();
        test_clamp();
        test_load_on_tick();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
